sensor_fault_monitor: RTL and testbench
=======================================

# sensor_fault_monitor

Downstream qualifier for the combinational sensor error detector: consumes its `error` flag plus the raw `sensors[3:0]` vector and turns the single-cycle combinational flag into a debounced, latched fault. Requires `error` to hold for `DEBOUNCE` consecutive clocks before declaring a fault. Captures the offending sensor pattern, keeps saturating event/glitch statistics, and holds the fault until software clears it.

## Interface
- `DEBOUNCE`, 4: consecutive high samples of `error` required to qualify a fault; legal range 1..16.
- `CNT_W`, 8: width of both statistics counters.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous reset, active-high; one clock, one reset domain.
- `sensors`  in  4  raw sensor vector, same cycle as `error`.
- `error`  in  1  combinational error flag from the detector.
- `clear`  in  1  fault acknowledge, single-cycle pulse or level.
- `fault`  out  1  latched, qualified fault.
- `fault_code`  out  4  `sensors` captured on the qualifying edge.
- `event_count`  out  CNT_W  number of qualified faults, saturating.
- `glitch_count`  out  CNT_W  number of error runs that ended before qualifying, saturating.

## Operation
- States:
  - IDLE: no fault, run counter 0.
  - QUAL: error run in progress.
  - FAULT: fault latched.
- IDLE:
  - `error`=1 and DEBOUNCE=1 -> FAULT (capture).
  - `error`=1 otherwise -> QUAL, run=1.
  - `error`=0 -> stay.
- QUAL:
  - `error`=0 -> IDLE, run=0, glitch_count+1.
  - `error`=1 and run==DEBOUNCE-1 -> FAULT (capture).
  - `error`=1 otherwise -> run+1.
- Capture, on the qualifying edge only:
  - `fault_code` <= `sensors`.
  - `event_count` +1.
- FAULT:
  - `clear`=1 and `error`=0 -> IDLE.
  - `clear`=1 while `error`=1 -> ignored, stay in FAULT. No new capture and no count change while in FAULT.
- `clear` has no effect in IDLE or QUAL.
- Run counter width: $clog2(DEBOUNCE+1); never exceeds DEBOUNCE-1.
- Counters:
  - Stop at all-ones; no wrap.
  - Cleared only by `rst`.
- `fault_code` holds its last captured value after clear until the next qualification.

## Timing
- All outputs are registered; nothing is combinational from an input.
- Reset values:
  - `fault`=0, `fault_code`=0, `event_count`=0, `glitch_count`=0.
  - State IDLE, run=0.
- Qualification latency: `error` high on DEBOUNCE consecutive rising edges means `fault`=1 immediately after the DEBOUNCE-th edge. The same applies to `fault_code` and `event_count`.
- Glitch: `glitch_count` updates on the edge where `error` is first sampled low in QUAL.
- Clear: `fault` falls after the edge sampling `clear`=1 and `error`=0.
- Back-to-back fault: the earliest re-qualification is DEBOUNCE edges after the clear edge.
- `rst` dominates every other input on the same edge, including mid-QUAL and mid-FAULT. No partial counts survive.

## Structure
- Shared package `sensor_pkg` holds:
  - The state enum typedef `mon_state_t` (IDLE, QUAL, FAULT).
  - The constant `SENSOR_W`=4, used for `sensors` and `fault_code`.
- Sub-module `sat_counter`, parameterised by width, with `clk`, `rst`, `inc` and `count` ports. It is instantiated twice, once for events and once for glitches.
- FSM and run counter live in the top module.

## Test plan
DEBOUNCE=4, CNT_W=8 unless noted.
- Reset: drive garbage inputs with `rst`=1 for 2 cycles -> all outputs 0.
- Glitch: `error`=1 for 3 cycles, then 0 -> `fault` stays 0, `glitch_count`=1, `event_count`=0.
- Qualify: `sensors`=4'b0110, `error`=1 for 4 cycles -> `fault`=1 after the 4th edge, `fault_code`=4'b0110, `event_count`=1. Holding `error` high for 10 more cycles changes nothing.
- Clear while active: `clear`=1 with `error`=1 -> `fault` stays 1. Then `error`=0 plus `clear`=1 -> `fault`=0 next edge, `fault_code` still 4'b0110.
- Saturation: CNT_W=2, 5 qualify/clear cycles -> `event_count` sticks at 3. DEBOUNCE=1: a single `error` cycle sets `fault` after one edge.
- Reset mid-operation: `rst` asserted at run=2 in QUAL, and separately while in FAULT -> IDLE, all outputs 0 on the next edge.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor fault monitor.
//   SENSOR_W    : width of the raw sensor vector and of the captured fault code
//   mon_state_t : monitor FSM state encoding
package sensor_pkg;

   localparam int SENSOR_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUAL  = 2'd1,
      FAULT = 2'd2
   } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. It counts one per cycle with inc high and stops at
// all-ones. It returns to zero only on the synchronous reset.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-high, clears the count
//   inc   : increment request
//   count : registered count value
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sensor_fault_monitor.sv
// Debounces the combinational sensor error flag into a latched fault.
// The flag must hold for DEBOUNCE consecutive clocks before a fault is declared.
// On that qualifying edge the monitor captures the sensor pattern. It also
// counts qualified faults and error runs that ended before qualifying.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high
//   sensors      : raw sensor vector, aligned with error
//   error        : error flag from the detector
//   clear        : fault acknowledge (pulse or level)
//   fault        : latched qualified fault
//   fault_code   : sensors captured on the qualifying edge
//   event_count  : qualified faults, saturating
//   glitch_count : error runs that ended before qualifying, saturating
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no fault, run counter 0
// QUAL  | error run in progress, run_q = samples so far
// FAULT | fault latched, waits for clear with error low
module sensor_fault_monitor
   import sensor_pkg::*;
#(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SENSOR_W-1:0] sensors,
   input  logic                error,
   input  logic                clear,
   output logic                fault,
   output logic [SENSOR_W-1:0] fault_code,
   output logic [CNT_W-1:0]    event_count,
   output logic [CNT_W-1:0]    glitch_count
);

   localparam int RUN_W = $clog2(DEBOUNCE + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);

   mon_state_t            state_q;
   logic [RUN_W-1:0]      run_q;
   logic                  fault_q;
   logic [SENSOR_W-1:0]   code_q;
   logic                  qual_pulse;
   logic                  glitch_pulse;

   // The counters take these pulses directly. Their registered outputs keep
   // every output of the block registered.
   always_comb begin
      qual_pulse   = 1'b0;
      glitch_pulse = 1'b0;
      case (state_q)
         IDLE:    qual_pulse   = error && (DEBOUNCE == 1);
         QUAL: begin
            qual_pulse   = error && (run_q == RUN_LAST);
            glitch_pulse = !error;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         run_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (error) begin
                  if (DEBOUNCE == 1) begin
                     state_q <= FAULT;
                     fault_q <= 1'b1;
                     code_q  <= sensors;
                  end else begin
                     state_q <= QUAL;
                     run_q   <= RUN_W'(1);
                  end
               end
            end
            QUAL: begin
               if (!error) begin
                  state_q <= IDLE;
                  run_q   <= '0;
               end else if (run_q == RUN_LAST) begin
                  state_q <= FAULT;
                  run_q   <= '0;
                  fault_q <= 1'b1;
                  code_q  <= sensors;
               end else begin
                  run_q   <= run_q + RUN_W'(1);
               end
            end
            FAULT: begin
               // A clear that arrives while the error is still present is dropped.
               if (clear && !error) begin
                  state_q <= IDLE;
                  fault_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               run_q   <= '0;
               fault_q <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_event_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (qual_pulse),
      .count (event_count)
   );

   sat_counter #(.W(CNT_W)) u_glitch_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (glitch_pulse),
      .count (glitch_count)
   );

   assign fault      = fault_q;
   assign fault_code = code_q;

endmodule

// File: tb/tb_sensor_fault_monitor.sv
module tb_sensor_fault_monitor;

   logic       clk;
   logic       rst;
   logic [3:0] sensors;
   logic       error;
   logic       clear;

   logic       fault_m;
   logic [3:0] code_m;
   logic [7:0] evt_m;
   logic [7:0] gl_m;

   logic       fault_s;
   logic [3:0] code_s;
   logic [1:0] evt_s;
   logic [1:0] gl_s;

   logic       fault_1;
   logic [3:0] code_1;
   logic [7:0] evt_1;
   logic [7:0] gl_1;

   int checks;
   int errors;

   sensor_fault_monitor #(.DEBOUNCE(4), .CNT_W(8)) dut_main (
      .clk(clk), .rst(rst), .sensors(sensors), .error(error), .clear(clear),
      .fault(fault_m), .fault_code(code_m), .event_count(evt_m), .glitch_count(gl_m)
   );

   sensor_fault_monitor #(.DEBOUNCE(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .sensors(sensors), .error(error), .clear(clear),
      .fault(fault_s), .fault_code(code_s), .event_count(evt_s), .glitch_count(gl_s)
   );

   sensor_fault_monitor #(.DEBOUNCE(1), .CNT_W(8)) dut_deb1 (
      .clk(clk), .rst(rst), .sensors(sensors), .error(error), .clear(clear),
      .fault(fault_1), .fault_code(code_1), .event_count(evt_1), .glitch_count(gl_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are set between edges, so outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; error = 1'b0; clear = 1'b0; sensors = 4'h0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sensors = 4'hF; error = 1'b1; clear = 1'b1;
      tick();
      tick();
      checks++;
      if (fault_m !== 1'b0 || code_m !== 4'h0 || evt_m !== 8'd0 || gl_m !== 8'd0) begin
         errors++;
         $display("FAIL reset_main: fault=%b code=%h evt=%0d glitch=%0d required 0/0/0/0",
                  fault_m, code_m, evt_m, gl_m);
      end
      checks++;
      if (fault_1 !== 1'b0 || code_1 !== 4'h0 || evt_1 !== 8'd0) begin
         errors++;
         $display("FAIL reset_deb1: fault=%b code=%h evt=%0d required 0/0/0",
                  fault_1, code_1, evt_1);
      end
      rst = 1'b0; error = 1'b0; clear = 1'b0; sensors = 4'h0;
      tick();
   endtask

   task automatic test_glitch();
      error = 1'b1; sensors = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (fault_m !== 1'b0) begin
            errors++;
            $display("FAIL glitch_run_%0d: fault=%b required 0", i, fault_m);
         end
      end
      error = 1'b0;
      tick();
      checks++;
      if (fault_m !== 1'b0 || gl_m !== 8'd1 || evt_m !== 8'd0) begin
         errors++;
         $display("FAIL glitch_end: fault=%b glitch=%0d evt=%0d required 0/1/0",
                  fault_m, gl_m, evt_m);
      end
   endtask

   task automatic test_qualify();
      sensors = 4'b0110; error = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (fault_m !== 1'b0) begin
            errors++;
            $display("FAIL qualify_early_edge%0d: fault=%b required 0", i, fault_m);
         end
      end
      tick();
      checks++;
      if (fault_m !== 1'b1 || code_m !== 4'b0110 || evt_m !== 8'd1) begin
         errors++;
         $display("FAIL qualify_edge4: fault=%b code=%b evt=%0d required 1/0110/1",
                  fault_m, code_m, evt_m);
      end
      sensors = 4'b1001;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (fault_m !== 1'b1 || code_m !== 4'b0110 || evt_m !== 8'd1 || gl_m !== 8'd1) begin
            errors++;
            $display("FAIL qualify_hold_%0d: fault=%b code=%b evt=%0d glitch=%0d required 1/0110/1/1",
                     i, fault_m, code_m, evt_m, gl_m);
         end
      end
   endtask

   task automatic test_clear_active();
      clear = 1'b1; error = 1'b1;
      tick();
      checks++;
      if (fault_m !== 1'b1) begin
         errors++;
         $display("FAIL clear_while_error: fault=%b required 1", fault_m);
      end
      error = 1'b0;
      tick();
      checks++;
      if (fault_m !== 1'b0 || code_m !== 4'b0110 || evt_m !== 8'd1) begin
         errors++;
         $display("FAIL clear_release: fault=%b code=%b evt=%0d required 0/0110/1",
                  fault_m, code_m, evt_m);
      end
      clear = 1'b0;
   endtask

   task automatic test_clear_ignored();
      // clear held through a short run must not change the run or the glitch count.
      clear = 1'b1; error = 1'b1;
      tick();
      tick();
      error = 1'b0;
      tick();
      checks++;
      if (fault_m !== 1'b0 || gl_m !== 8'd2 || code_m !== 4'b0110) begin
         errors++;
         $display("FAIL clear_in_idle_qual: fault=%b glitch=%0d code=%b required 0/2/0110",
                  fault_m, gl_m, code_m);
      end
      clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      sensors = 4'b1010; error = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (fault_m !== 1'b1 || code_m !== 4'b1010 || evt_m !== 8'd2) begin
         errors++;
         $display("FAIL b2b_first: fault=%b code=%b evt=%0d required 1/1010/2",
                  fault_m, code_m, evt_m);
      end
      error = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0; error = 1'b1; sensors = 4'b0101;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (fault_m !== 1'b0 || code_m !== 4'b1010) begin
         errors++;
         $display("FAIL b2b_edge3: fault=%b code=%b required 0/1010", fault_m, code_m);
      end
      tick();
      checks++;
      if (fault_m !== 1'b1 || code_m !== 4'b0101 || evt_m !== 8'd3) begin
         errors++;
         $display("FAIL b2b_edge4: fault=%b code=%b evt=%0d required 1/0101/3",
                  fault_m, code_m, evt_m);
      end
      error = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset_mid();
      sensors = 4'b1100; error = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (fault_m !== 1'b0 || code_m !== 4'h0 || evt_m !== 8'd0 || gl_m !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_qual: fault=%b code=%h evt=%0d glitch=%0d required 0/0/0/0",
                  fault_m, code_m, evt_m, gl_m);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (fault_m !== 1'b0) begin
         errors++;
         $display("FAIL reset_run_restart: fault=%b required 0", fault_m);
      end
      tick();
      checks++;
      if (fault_m !== 1'b1 || code_m !== 4'b1100 || evt_m !== 8'd1) begin
         errors++;
         $display("FAIL requalify_after_reset: fault=%b code=%b evt=%0d required 1/1100/1",
                  fault_m, code_m, evt_m);
      end
      rst = 1'b1; clear = 1'b1;
      tick();
      checks++;
      if (fault_m !== 1'b0 || code_m !== 4'h0 || evt_m !== 8'd0 || gl_m !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_fault: fault=%b code=%h evt=%0d glitch=%0d required 0/0/0/0",
                  fault_m, code_m, evt_m, gl_m);
      end
      rst = 1'b0; error = 1'b0; clear = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sensors = 4'(i + 1); error = 1'b1;
         for (int k = 0; k < 4; k++) tick();
         exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
         checks++;
         if (fault_s !== 1'b1 || evt_s !== exp_cnt || code_s !== 4'(i + 1)) begin
            errors++;
            $display("FAIL saturation_%0d: fault=%b evt=%0d code=%h required 1/%0d/%h",
                     i, fault_s, evt_s, code_s, exp_cnt, 4'(i + 1));
         end
         error = 1'b0; clear = 1'b1;
         tick();
         clear = 1'b0;
      end
   endtask

   task automatic test_debounce_one();
      do_reset();
      sensors = 4'b1011; error = 1'b1;
      tick();
      checks++;
      if (fault_1 !== 1'b1 || code_1 !== 4'b1011 || evt_1 !== 8'd1) begin
         errors++;
         $display("FAIL deb1_single_edge: fault=%b code=%b evt=%0d required 1/1011/1",
                  fault_1, code_1, evt_1);
      end
      checks++;
      if (fault_m !== 1'b0) begin
         errors++;
         $display("FAIL deb4_single_edge: fault=%b required 0", fault_m);
      end
      error = 1'b0;
      tick();
      checks++;
      if (fault_1 !== 1'b1 || gl_1 !== 8'd0 || gl_m !== 8'd1) begin
         errors++;
         $display("FAIL deb1_latched: fault1=%b glitch1=%0d glitch_main=%0d required 1/0/1",
                  fault_1, gl_1, gl_m);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; sensors = 4'h0; error = 1'b0; clear = 1'b0;
      test_reset();
      test_glitch();
      test_qualify();
      test_clear_active();
      test_clear_ignored();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      test_debounce_one();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
